// File: rtl/udiv16x8_seq.sv
// Sequential radix-2 restoring unsigned divider (DIVIDEND_W / DIVISOR_W),
// one quotient bit per clock, valid/ready on both the operand and result sides.
module udiv16x8_seq #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int DD = DIVIDEND_W;
  localparam int DS = DIVISOR_W;
  localparam int CW = (DD > 2) ? $clog2(DD) : 1;
  localparam logic [CW-1:0] LAST = CW'(DD - 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef logic [DS:0] rem_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rem_t            rem_q, rem_d;
  logic [DD-1:0]   dvd_q, dvd_d;
  logic [DS-1:0]   dvs_q, dvs_d;
  logic [DD-1:0]   quot_q, quot_d;
  logic [DS-1:0]   remo_q, remo_d;
  logic            dbz_q, dbz_d;

  // One restoring step, shared by the accept cycle and CALC.
  rem_t            step_rem_in, step_rem;
  logic [DD-1:0]   step_dvd_in, step_dvd;
  logic [DS-1:0]   step_dvs;
  logic [DS+1:0]   sh_rem, dvs_ext;
  logic            ge;

  always_comb begin
    step_rem_in = (state_q == IDLE) ? '0       : rem_q;
    step_dvd_in = (state_q == IDLE) ? dividend : dvd_q;
    step_dvs    = (state_q == IDLE) ? divisor  : dvs_q;
    sh_rem      = {step_rem_in, step_dvd_in[DD-1]};
    dvs_ext     = {2'b00, step_dvs};
    ge          = (sh_rem >= dvs_ext);
    step_rem    = ge ? rem_t'(sh_rem - dvs_ext) : sh_rem[DS:0];
    step_dvd    = {step_dvd_in[DD-2:0], ge};
  end

  // The first quotient bit is resolved in the accept cycle (partial remainder
  // starts from zero), so a nonzero result is visible DIVIDEND_W cycles after
  // acceptance while a zero divisor is answered in the very next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            rem_d   = '0;
            dvd_d   = dividend;
            quot_d  = '1;
            remo_d  = dividend[DS-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            rem_d   = step_rem;
            dvd_d   = step_dvd;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = step_dvd;
          remo_d  = step_rem[DS-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_udiv16x8_seq.sv
// Directed + swept checks of udiv16x8_seq against a plain-arithmetic model;
// one negedge process compares every valid result cycle.
module tb_udiv16x8_seq;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [15:0] dividend, quotient;
  logic [7:0]  divisor, remainder;

  int checks = 0;
  int errors = 0;

  // model state for the in-flight operation
  logic [15:0] exp_a, exp_q;
  logic [7:0]  exp_b, exp_r;
  logic        exp_z;
  int          exp_lat;
  logic        pend = 1'b0;
  logic        seen = 1'b0;
  longint      t_acc = 0;

  udiv16x8_seq #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!pend) chk("spurious_out_valid", 1, 0);
      else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", ($time - t_acc + 5) / 10, exp_lat);
        end
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
        chk("div_by_zero", div_by_zero, exp_z);
        if (!exp_z) begin
          chk("invariant", longint'(quotient) * exp_b + remainder, exp_a);
          chk("rem_lt_div", remainder < exp_b, 1);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    t_acc = $time;
    exp_a = a; exp_b = b;
    exp_z = (b == 0);
    exp_q = exp_z ? 16'hFFFF : a / {8'd0, b};
    exp_r = exp_z ? a[7:0] : 8'(a % {8'd0, b});
    exp_lat = exp_z ? 1 : 16;
    seen = 1'b0;
    pend = 1'b1;
    #1 in_valid = 1'b0; dividend = 16'($urandom); divisor = 8'($urandom);
  endtask

  // waits for out_valid; returns 0 on timeout
  task automatic wait_valid(output bit ok);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    ok = out_valid;
    if (!ok) begin chk("out_valid_timeout", 0, 1); pend = 1'b0; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    pend = 1'b0;
    #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("dbz_after_hs", div_by_zero, 0);
  endtask

  task automatic run(input logic [15:0] a, input logic [7:0] b, input int hold,
                     input bit lit, input int lq, input int lr, input int lz);
    bit ok;
    out_ready = (hold == 0);
    send(a, b);
    wait_valid(ok);
    if (!ok) return;
    if (lit) begin
      chk("lit_quotient", quotient, lq);
      chk("lit_remainder", remainder, lr);
      chk("lit_dbz", div_by_zero, lz);
    end
    repeat (hold) @(negedge clk);
    handshake();
  endtask

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    run(16'd1000, 8'd7, 0, 1, 142, 6, 0);
    run(16'hFFFF, 8'hFF, 0, 1, 16'h0101, 0, 0);
    run(16'hFFFF, 8'h01, 0, 1, 16'hFFFF, 0, 0);
    run(16'd5, 8'd9, 0, 1, 0, 5, 0);
    run(16'h1234, 8'd0, 0, 1, 16'hFFFF, 8'h34, 1);
    run(16'd100, 8'd10, 0, 1, 10, 0, 0);

    // held result; operands pulsed while busy must be ignored
    out_ready = 1'b0;
    send(16'd200, 8'd3);
    @(negedge clk);
    in_valid = 1'b1; dividend = 16'd9; divisor = 8'd2;
    chk("busy_in_ready", in_ready, 0);
    wait_valid(ok);
    if (ok) begin
      chk("lit_quotient_200_3", quotient, 66);
      chk("lit_remainder_200_3", remainder, 2);
      repeat (5) @(negedge clk);
      chk("done_in_ready", in_ready, 0);
      handshake();
    end
    in_valid = 1'b0;
    run(16'd9, 8'd2, 0, 1, 4, 1, 0);

    // reset in the middle of CALC
    out_ready = 1'b0;
    send(16'hBEEF, 8'h13);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    pend = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    repeat (20) @(negedge clk);
    // 2572*19 + 11 = 48879
    run(16'hBEEF, 8'h13, 0, 1, 16'h0A0C, 8'h0B, 0);

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom);
      case (i % 8)
        0: b = 8'd0;
        1: b = 8'hFF;
        2: a = 16'hFFFF;
        3: a = 16'd0;
        4: begin a = 16'hFFFF; b = 8'd1; end
        default: ;
      endcase
      run(a, b, int'($urandom_range(0, 2)), 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
